// File: rtl/spi_rx_pkg.sv
// Shared types and sizing helpers for the spi_slave_rx receive path.
package spi_rx_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, SHIFT} rx_state_t;

   localparam int WORD_BITS_DEF  = 16;
   localparam int FIFO_DEPTH_DEF = 4;

   // Width of an occupancy counter that must represent 0..depth inclusive.
   function automatic int clog2_level(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through FIFO; DEPTH must be a power of two so pointers wrap naturally.
module spi_rx_fifo
   import spi_rx_pkg::*;
#(
   parameter int WIDTH = WORD_BITS_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head,
   output logic [clog2_level(DEPTH)-1:0] level,
   output logic                          full,
   output logic                          empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = clog2_level(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampled 3-wire SPI receiver feeding a FWFT word FIFO.
// Define SPI_RX_ERR_CNT_EN to add the saturating err_count output.
module spi_slave_rx
   import spi_rx_pkg::*;
#(
   parameter int WORD_BITS   = WORD_BITS_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               sclk,
   input  logic                               sync,
   input  logic                               mosi,
   output logic [WORD_BITS-1:0]               rx_data,
   output logic                               rx_valid,
   input  logic                               rx_ready,
   output logic [clog2_level(FIFO_DEPTH)-1:0] fifo_level,
   output logic                               busy,
   output logic                               frame_abort,
   output logic                               overflow,
   input  logic                               clear_ovf
`ifdef SPI_RX_ERR_CNT_EN
   ,
   output logic [7:0]                         err_count
`endif
);

   localparam int BW = $clog2(WORD_BITS + 1);

   logic [SYNC_STAGES-1:0] sclk_sr, sync_sr, mosi_sr;
   logic                   sclk_hist;
   logic                   s_sclk, s_sync, s_mosi;
   logic                   rise, fall;

   rx_state_t              state, state_nxt;
   logic [WORD_BITS-1:0]   shreg, shreg_nxt, shifted;
   logic [BW-1:0]          bitcnt, bitcnt_nxt;
   logic                   abort_nxt, wc_nxt, wc_q;
   logic                   wr_en;
   logic [WORD_BITS-1:0]   wr_data;
   logic                   fifo_full, fifo_empty, dropped;

   assign s_sclk  = sclk_sr[SYNC_STAGES-1];
   assign s_sync  = sync_sr[SYNC_STAGES-1];
   assign s_mosi  = mosi_sr[SYNC_STAGES-1];
   assign rise    = s_sclk & ~sclk_hist;
   assign fall    = ~s_sclk & sclk_hist;
   assign shifted = {shreg[WORD_BITS-2:0], s_mosi};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sr   <= '0;
         sync_sr   <= '0;
         mosi_sr   <= '0;
         sclk_hist <= 1'b0;
      end else begin
         sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         sync_sr   <= {sync_sr[SYNC_STAGES-2:0], sync};
         mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_hist <= s_sclk;
      end
   end

   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      bitcnt_nxt = bitcnt;
      abort_nxt  = 1'b0;
      wc_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (rise && s_sync) begin
               state_nxt  = ARMED;
               shreg_nxt  = '0;
               bitcnt_nxt = '0;
            end
         end
         ARMED, SHIFT: begin
            if (rise && s_sync) begin
               abort_nxt  = 1'b1;
               state_nxt  = ARMED;
               shreg_nxt  = '0;
               bitcnt_nxt = '0;
            end else if (fall) begin
               shreg_nxt  = shifted;
               bitcnt_nxt = (state == ARMED) ? BW'(1) : bitcnt + BW'(1);
               state_nxt  = SHIFT;
               if (bitcnt_nxt == BW'(WORD_BITS)) begin
                  wc_nxt    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bitcnt      <= '0;
         frame_abort <= 1'b0;
         wc_q        <= 1'b0;
         wr_en       <= 1'b0;
         wr_data     <= '0;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         bitcnt      <= bitcnt_nxt;
         frame_abort <= abort_nxt;
         wc_q        <= wc_nxt;
         // shreg still holds the finished word here: the next sclk rise is >=3 clks away.
         wr_en       <= wc_q;
         wr_data     <= shreg;
      end
   end

   assign busy     = (state != IDLE);
   assign rx_valid = ~fifo_empty;
   assign dropped  = wr_en & fifo_full & ~(rx_ready & rx_valid);

   spi_rx_fifo #(
      .WIDTH (WORD_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (rx_ready),
      .head      (rx_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            overflow <= 1'b0;
      else if (dropped)   overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
   end

`ifdef SPI_RX_ERR_CNT_EN
   logic [1:0] err_inc;
   logic [8:0] err_sum;

   // Clearing zeroes the base, so a same-cycle event still lands as 1 or 2.
   assign err_inc = {1'b0, frame_abort} + {1'b0, dropped};
   assign err_sum = (clear_ovf ? 9'd0 : {1'b0, err_count}) + {7'd0, err_inc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_count <= '0;
      else     err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
   end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scenario-based bench for spi_slave_rx with a queue-based word model.
// Build with SPI_RX_ERR_CNT_EN defined to also cover err_count.
module tb_spi_slave_rx;

   localparam int S = 2;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst, sclk, sync, mosi, rx_ready, clear_ovf;
   logic [15:0] rx_data;
   logic        rx_valid, busy, frame_abort, overflow;
   logic [2:0]  fifo_level;
`ifdef SPI_RX_ERR_CNT_EN
   logic [7:0]  err_count;
`endif

   int checks = 0;
   int errors = 0;
   int abort_cnt = 0;

   spi_slave_rx #(
      .WORD_BITS   (16),
      .FIFO_DEPTH  (D),
      .SYNC_STAGES (S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .sync        (sync),
      .mosi        (mosi),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .fifo_level  (fifo_level),
      .busy        (busy),
      .frame_abort (frame_abort),
      .overflow    (overflow),
      .clear_ovf   (clear_ovf)
`ifdef SPI_RX_ERR_CNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_abort === 1'b1) abort_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   // One sclk high phase (mosi changes on the rise), then sclk falls.
   task automatic spi_bit(input logic b, input logic s, input int h);
      sclk = 1'b1; sync = s; mosi = b;
      repeat (h) @(negedge clk);
      sclk = 1'b0; sync = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] w, input int n, input int h);
      for (int i = 0; i < n; i++) begin
         spi_bit(w[15-i], (i == 0), h);
         repeat (h) @(negedge clk);
      end
   endtask

   task automatic pop_word(output logic [15:0] d, output logic ok);
      ok = 1'b0;
      d  = '0;
      for (int c = 0; c < 50 && !ok; c++) begin
         if (rx_valid === 1'b1) begin
            d = rx_data; ok = 1'b1; rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sclk = 0; sync = 0; mosi = 0; rx_ready = 0; clear_ovf = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rx_data, rx_valid, fifo_level, busy, frame_abort, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got data=%h v=%b lvl=%0d busy=%b ab=%b ovf=%b exp all 0",
                  rx_data, rx_valid, fifo_level, busy, frame_abort, overflow);
      end
`ifdef SPI_RX_ERR_CNT_EN
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
`endif
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      logic [15:0] w = 16'hA5C3;
      int lat = 0;
      logic seen = 1'b0;
      send_bits(w, 15, 4);
      spi_bit(w[0], 1'b0, 4);
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (rx_valid === 1'b1) begin seen = 1'b1; lat = c; end
      end
      checks++;
      if (lat != S + 3) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, S + 3); end
      @(negedge clk);
      checks++;
      if (rx_data !== w) begin errors++; $display("FAIL single_data got %h exp %h", rx_data, w); end
      checks++;
      if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", fifo_level); end
      rx_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", fifo_level); end
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [15:0] q[$];
      logic [15:0] d;
      logic ok;
      int n = 5;
      for (int i = 1; i <= n; i++) begin
         q.push_back(16'(i));
         send_bits(16'(i), 16, 4);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (fifo_level !== 3'((n < D) ? n : D)) begin errors++; $display("FAIL ovf_level got %0d exp %0d", fifo_level, D); end
      checks++;
      if (overflow !== (n > D)) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
`ifdef SPI_RX_ERR_CNT_EN
      checks++;
      if (err_count !== 8'(n - D)) begin errors++; $display("FAIL ovf_err got %0d exp %0d", err_count, n - D); end
`endif
      for (int i = 0; i < D; i++) begin
         pop_word(d, ok);
         checks++;
         if (!ok || d !== q[i]) begin errors++; $display("FAIL ovf_drain%0d got %h ok=%b exp %h", i, d, ok, q[i]); end
      end
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got valid=%b exp 0", rx_valid); end
      clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
`ifdef SPI_RX_ERR_CNT_EN
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL ovf_err_clear got %0d exp 0", err_count); end
`endif
   endtask

   task automatic test_abort();
      int a0 = abort_cnt;
      logic [15:0] d;
      logic ok;
      send_bits(16'hBEEF, 7, 4);
      send_bits(16'h1234, 16, 4);
      repeat (10) @(negedge clk);
      checks++;
      if (abort_cnt - a0 != 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", abort_cnt - a0); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++;
      if (fifo_level !== 3'd1) begin errors++; $display("FAIL abort_level got %0d exp 1", fifo_level); end
`ifdef SPI_RX_ERR_CNT_EN
      checks++;
      if (err_count !== 8'd1) begin errors++; $display("FAIL abort_err got %0d exp 1", err_count); end
`endif
      pop_word(d, ok);
      checks++;
      if (!ok || d !== 16'h1234) begin errors++; $display("FAIL abort_word got %h ok=%b exp 1234", d, ok); end
   endtask

   task automatic test_reset_mid();
      int a0;
      logic [15:0] d;
      logic ok;
      send_bits(16'h5A5A, 16, 4);
      repeat (8) @(negedge clk);
      a0 = abort_cnt;
      send_bits(16'hFFFF, 10, 4);
      rst = 1'b1;
      #1;
      checks++;
      if ({rx_data, rx_valid, fifo_level, busy, frame_abort, overflow} !== '0) begin
         errors++;
         $display("FAIL rstmid_async got data=%h v=%b lvl=%0d busy=%b exp all 0", rx_data, rx_valid, fifo_level, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({rx_data, rx_valid, fifo_level, busy, frame_abort, overflow} !== '0) begin
         errors++;
         $display("FAIL rstmid_held got data=%h v=%b lvl=%0d busy=%b exp all 0", rx_data, rx_valid, fifo_level, busy);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send_bits(16'hFFFF, 16, 4);
      repeat (10) @(negedge clk);
      checks++;
      if (abort_cnt != a0) begin errors++; $display("FAIL rstmid_abort got %0d exp 0", abort_cnt - a0); end
      checks++;
      if (fifo_level !== 3'd1) begin errors++; $display("FAIL rstmid_level got %0d exp 1", fifo_level); end
      pop_word(d, ok);
      checks++;
      if (!ok || d !== 16'hFFFF) begin errors++; $display("FAIL rstmid_word got %h ok=%b exp ffff", d, ok); end
   endtask

   task automatic test_stream();
      logic [15:0] exp_q[$];
      logic [15:0] got[$];
      int n = 6;
      for (int i = 0; i < n; i++) exp_q.push_back(16'($urandom));
      fork
         begin
            for (int i = 0; i < n; i++) send_bits(exp_q[i], 16, 3);
         end
         begin
            for (int c = 0; c < 3000 && got.size() < n; c++) begin
               @(negedge clk);
               rx_ready = ~rx_ready;
               #1;
               if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
            end
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      checks++;
      if (got.size() != n) begin errors++; $display("FAIL stream_count got %0d exp %0d", got.size(), n); end
      for (int i = 0; i < n && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stream_word%0d got %h exp %h", i, got[i], exp_q[i]); end
      end
      checks++;
      if (overflow !== 1'b0 || fifo_level !== 3'd0) begin
         errors++; $display("FAIL stream_end got ovf=%b lvl=%0d exp 0/0", overflow, fifo_level);
      end
   endtask

   task automatic test_push_pop();
      logic [15:0] w[5];
      logic [15:0] d;
      logic ok;
      for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
      for (int i = 0; i < D; i++) send_bits(w[i], 16, 4);
      repeat (10) @(negedge clk);
      send_bits(w[4], 15, 4);
      d = w[4];
      spi_bit(d[0], 1'b0, 4);
      repeat (S + 2) @(negedge clk);
      checks++;
      if (fifo_level !== 3'(D) || rx_data !== w[0]) begin
         errors++; $display("FAIL pp_before got lvl=%0d data=%h exp %0d/%h", fifo_level, rx_data, D, w[0]);
      end
      rx_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (fifo_level !== 3'(D)) begin errors++; $display("FAIL pp_level got %0d exp %0d", fifo_level, D); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow got %b exp 0", overflow); end
      @(negedge clk);
      rx_ready = 1'b0;
      for (int i = 1; i < 5; i++) begin
         pop_word(d, ok);
         checks++;
         if (!ok || d !== w[i]) begin errors++; $display("FAIL pp_drain%0d got %h ok=%b exp %h", i, d, ok, w[i]); end
      end
   endtask

   task automatic test_sync_idle();
      int a0 = abort_cnt;
      sync = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_sync_busy got %b exp 0", busy); end
      sync = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rx_valid !== 1'b0 || abort_cnt != a0) begin
         errors++; $display("FAIL idle_sync_after got busy=%b valid=%b aborts=%0d exp 0/0/0", busy, rx_valid, abort_cnt - a0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_abort();
      test_reset_mid();
      test_stream();
      test_push_pop();
      test_sync_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
